cla_rr_arbiter: RTL and testbench

- Shares one N-bit carry-lookahead adder among NREQ requesters.
- A round-robin arbiter picks one pending request per cycle and drives its operands into an internal CLA_generate instance with cin tied to 0.
- The (N+1)-bit sum is captured in a one-entry output register, tagged with the requester index.
- Sits between the issue logic and any consumers of wide integer adds; removes the need to replicate the N-bit adder per requester.

---
 rtl/cla_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cla_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_rr_arbiter.sv
// cla_rr_arbiter: one shared N-bit carry-lookahead adder, fed by a
// round-robin arbiter over NREQ requesters, result held in a one-entry slot.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The requester holds valid and operands stable until ready.
// A requester may drop valid before it is granted. The consumer sees
// res_valid/res_data/res_id stable until it raises res_ready.

// CLA_generate: parallel-prefix (Kogge-Stone) carry lookahead adder.
module CLA_generate #(
  parameter int N = 50
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int LVLS = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] prop0;
  logic [N-1:0] gen_c;
  logic [N-1:0] prop_c;
  logic [N-1:0] gen_n;
  logic [N-1:0] prop_n;
  logic [N:0]   carry;

  // Prefix tree: after LVLS levels gen_c[i]/prop_c[i] cover bits [i:0]
  always_comb begin
    prop0  = a_i ^ b_i;
    gen_c  = a_i & b_i;
    prop_c = prop0;
    gen_n  = '0;
    prop_n = '0;
    carry  = '0;
    for (int k = 0; k < LVLS; k++) begin
      gen_n  = gen_c;
      prop_n = prop_c;
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << k)) begin
          gen_n[i]  = gen_c[i] | (prop_c[i] & gen_c[i - (1 << k)]);
          prop_n[i] = prop_c[i] & prop_c[i - (1 << k)];
        end
      end
      gen_c  = gen_n;
      prop_c = prop_n;
    end
    carry[0] = cin_i;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = gen_c[i] | (prop_c[i] & cin_i);
    end
  end

  assign sum_o  = prop0 ^ carry[N-1:0];
  assign cout_o = carry[N];

endmodule

module cla_rr_arbiter #(
  parameter int N    = 50,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N:0]        res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy,
  output logic              dbg_state_o,
  output logic [IDW-1:0]    dbg_rr_ptr_o
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  slot_state_e    state_q, state_d;
  logic [N:0]     res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           slot_free;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic           req_hs;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  assign slot_free = (state_q == SLOT_EMPTY) || res_ready;

  // Round-robin search: first pending request at or above rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr_q + IDW'(k);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign req_hs    = slot_free && grant_found;
  assign req_ready = req_hs ? (NREQ'(1) << grant_idx) : '0;

  assign op_a = req_a[grant_idx*N +: N];
  assign op_b = req_b[grant_idx*N +: N];

  CLA_generate #(.N(N)) u_cla (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Slot FSM next state plus result/pointer loads on a request handshake
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      SLOT_EMPTY: if (req_hs) state_d = SLOT_FULL;
      SLOT_FULL:  if (res_ready && !req_hs) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (req_hs) begin
      res_data_d = {add_cout, add_sum};
      res_id_d   = grant_idx;
      rr_ptr_d   = grant_idx + IDW'(1);
    end
  end

  // State and result registers; reset drops any held result immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SLOT_EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign res_valid    = (state_q == SLOT_FULL);
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign busy         = res_valid || (|req_valid);
  assign dbg_state_o  = (state_q == SLOT_FULL);
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// tb_cla_rr_arbiter: vector table plus directed sequences, with a
// reference model and result scoreboard running on every falling edge.
module tb_cla_rr_arbiter;

  localparam int N    = 50;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + N + 1;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [N:0]        res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;
  logic              dbg_state;
  logic [IDW-1:0]    dbg_rr_ptr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic         m_full = 1'b0;
  logic [1:0]   m_ptr  = 2'd0;

  cla_rr_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_id       (res_id),
    .busy         (busy),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[N-1:0];
  endfunction

  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic [1:0] p, input logic free);
    logic [1:0] idx;
    model_grant = 4'b0000;
    if (free) begin
      for (int k = 3; k >= 0; k--) begin
        idx = p + 2'(k);
        if (v[idx]) model_grant = 4'b0001 << idx;
      end
    end
  endfunction

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  // ---------------- model + scoreboard ----------------
  initial begin
    logic [3:0]   g;
    logic [1:0]   gi;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_full = 1'b0;
        m_ptr  = 2'd0;
        exp_q.delete();
      end else begin
        g = model_grant(req_valid, m_ptr, !m_full || res_ready);
        check("mon_req_ready", 64'(req_ready), 64'(g));
        check("mon_res_valid", 64'(res_valid), 64'(m_full));
        check("mon_busy", 64'(busy), 64'(m_full || (|req_valid)));
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got id %0d data 0x%0h, required no result", res_id, res_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_res_id", 64'(res_id), 64'(e[W-1 -: IDW]));
            check("sb_res_data", 64'(res_data), 64'(e[N:0]));
          end
        end
        if (g != 4'b0000) begin
          gi = 2'd0;
          for (int i = 0; i < 4; i++) if (g[i]) gi = 2'(i);
          exp_q.push_back({gi, ref_add(req_a[gi*N +: N], req_b[gi*N +: N])});
          m_full = 1'b1;
          m_ptr  = gi + 2'd1;
        end else if (m_full && res_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   exp_ready;
    logic [1:0]   exp_id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [N-1:0] ta;
    logic [N-1:0] tb;
    logic [N:0]   carry_only;

    // Table: applied in order from rr_ptr=0 right after reset
    carry_only = '0;
    carry_only[N] = 1'b1;
    tbl[0] = '{4'b0100, 4'b0100, 2'd2, N'(5), N'(7), (N+1)'(12)};
    tbl[1] = '{4'b0001, 4'b0001, 2'd0, {N{1'b1}}, N'(1), carry_only};
    for (int i = 2; i < 8; i++) begin
      ta = rnd_op();
      tb = rnd_op();
      tbl[i] = '{4'b0000, 4'b0000, 2'd0, ta, tb, ref_add(ta, tb)};
    end
    tbl[2].valid = 4'b1111; tbl[2].exp_ready = 4'b0010; tbl[2].exp_id = 2'd1;
    tbl[3].valid = 4'b1001; tbl[3].exp_ready = 4'b1000; tbl[3].exp_id = 2'd3;
    tbl[4].valid = 4'b1010; tbl[4].exp_ready = 4'b0010; tbl[4].exp_id = 2'd1;
    tbl[5].valid = 4'b0011; tbl[5].exp_ready = 4'b0001; tbl[5].exp_id = 2'd0;
    tbl[6].valid = 4'b0000; tbl[6].exp_ready = 4'b0000; tbl[6].exp_id = 2'd0;
    tbl[7].valid = 4'b0001; tbl[7].exp_ready = 4'b0001; tbl[7].exp_id = 2'd0;

    // ---- reset ----
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    reset_n = 1'b1;

    // ---- table ----
    for (int v = 0; v < 8; v++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (tbl[v].exp_ready != 4'b0000 && i == int'(tbl[v].exp_id)) set_op(i, tbl[v].a, tbl[v].b);
        else set_op(i, rnd_op(), rnd_op());
      end
      req_valid = tbl[v].valid;
      @(negedge clk);
      check($sformatf("tbl%0d_req_ready", v), 64'(req_ready), 64'(tbl[v].exp_ready));
      step();
      req_valid = '0;
      @(negedge clk);
      check($sformatf("tbl%0d_res_valid", v), 64'(res_valid), 64'(tbl[v].exp_ready != 4'b0000));
      if (tbl[v].exp_ready != 4'b0000) begin
        check($sformatf("tbl%0d_res_data", v), 64'(res_data), 64'(tbl[v].exp_data));
        check($sformatf("tbl%0d_res_id", v), 64'(res_id), 64'(tbl[v].exp_id));
      end
    end

    // ---- round robin, all requesters continuously valid ----
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_req_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c > 0) begin
        check("rr_res_valid", 64'(res_valid), 64'd1);
        check("rr_res_id", 64'(res_id), 64'((c - 1) % 4));
      end
      step();
    end
    req_valid = '0;
    step();

    // ---- backpressure ----
    set_op(0, N'(100), N'(23));
    set_op(1, N'(7), N'(8));
    set_op(3, rnd_op(), rnd_op());
    req_valid = 4'b0001;
    @(negedge clk);
    check("bp_first_grant", 64'(req_ready), 64'd1);
    step();
    res_ready = 1'b0;
    req_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_data", 64'(res_data), 64'd123);
      check("bp_res_id", 64'(res_id), 64'd0);
      check("bp_rr_ptr", 64'(dbg_rr_ptr), 64'd1);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_reload_valid", 64'(res_valid), 64'd1);
    check("bp_reload_id", 64'(res_id), 64'd1);
    check("bp_reload_data", 64'(res_data), 64'd15);
    check("bp_next_grant", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    check("bp_last_id", 64'(res_id), 64'd3);
    step();

    // ---- withdrawal while FULL ----
    set_op(0, rnd_op(), rnd_op());
    set_op(1, rnd_op(), rnd_op());
    req_valid = 4'b0001;
    @(negedge clk);
    check("wd_grant0", 64'(req_ready), 64'd1);
    step();
    res_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    check("wd_held_ready", 64'(req_ready), 64'd0);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("wd_drop_ready", 64'(req_ready), 64'd0);
    check("wd_held_id", 64'(res_id), 64'd0);
    step();
    res_ready = 1'b1;
    @(negedge clk);
    check("wd_release_ready", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("wd_empty_valid", 64'(res_valid), 64'd0);
    check("wd_idle_busy", 64'(busy), 64'd0);
    step();

    // ---- reset mid-operation ----
    set_op(3, rnd_op() | N'(1), rnd_op());
    req_valid = 4'b1000;
    @(negedge clk);
    check("mr_grant3", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    check("mr_full_id", 64'(res_id), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_res_valid", 64'(res_valid), 64'd0);
    check("mr_res_data", 64'(res_data), 64'd0);
    check("mr_res_id", 64'(res_id), 64'd0);
    check("mr_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    @(negedge clk);
    step();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = 4'b1111;
    @(negedge clk);
    check("mr_after_grant", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("mr_after_id", 64'(res_id), 64'd0);
    repeat (3) step();

    // ---- final report ----
    @(negedge clk);
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
